if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline, driving the ID stage.
- Owns the PC register and issues instruction SRAM read requests.
- Produces if_to_id_bus {ce, pc}; ID reads inst_sram_rdata one cycle later.
- Consumes br_bus {br_e, br_addr} from ID. Holds a redirect that arrives during a PC stall until the PC can advance, and accepts an exception flush redirect.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first fetched instruction.
- Bus widths IF_TO_ID_WD (33), BR_WD (33) and StallBus (6) come from lib/defines.vh; Stop=1, NoStop=0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stall  in  StallBus  pipeline stall vector; bit 0 freezes the PC.
- flush  in  1  exception/eret redirect, highest priority.
- flush_pc  in  32  target of flush.
- br_bus  in  BR_WD  {br_e[32], br_addr[31:0]} from ID.
- if_to_id_bus  out  IF_TO_ID_WD  {ce[32], pc[31:0]}.
- inst_sram_en  out  1  instruction SRAM read enable.
- inst_sram_wen  out  4  tied 4'b0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  tied 32'b0.
- fetch_adel  out  1  misaligned fetch address flag.
- fetch_badvaddr  out  32  offending PC when fetch_adel=1, else 0.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset state: pc_reg=RESET_PC-4, ce_reg=0, pend_valid=0, pend_addr=0. All outputs deasserted or 0 during reset, except pc field = RESET_PC-4.
- ce_reg: becomes 1 on the first clk after rst deasserts; stays 1 until the next reset.
- Next-PC priority, evaluated each cycle:
  - flush: flush_pc
  - else br_e: br_addr
  - else pend_valid: pend_addr
  - else pc_reg+4 (32-bit wrap, no carry out).
- PC update:
  - flush=1: pc_reg<=flush_pc regardless of stall[0]; pend_valid<=0.
  - Else stall[0]==NoStop: pc_reg<=next_pc; pend_valid<=0.
  - Else (stall[0]==Stop): pc_reg holds. If br_e=1, pend_valid<=1 and pend_addr<=br_addr. Otherwise pending state holds.
- A branch seen during a stall is therefore never lost.
- A live br_e overrides an older pending target (last redirect wins).
- Delay slot is implicit. When ID holds a branch at PC P, pc_reg already equals P+4 and that fetch proceeds; the target is fetched next. No squash of the delay slot.
- inst_sram_addr = pc_reg, combinational.
- inst_sram_en = ce_reg & ~misaligned, where misaligned = (pc_reg[1:0]!=2'b00).
- if_to_id_bus = {ce_reg & ~misaligned, pc_reg}. A misaligned fetch is delivered to ID as a bubble.
- fetch_adel = ce_reg & misaligned.
- fetch_badvaddr = fetch_adel ? pc_reg : 0.
- Flush and br_e in the same cycle: flush wins, branch discarded, pending cleared.
- Reset during a pending branch: pending cleared; fetch restarts at RESET_PC.
- No SRAM handshake: single-cycle synchronous SRAM. Stall is the only backpressure.

Test Plan:
- Reset/start: rst high 3 cycles, then low → cycle 0 after release: ce=0, pc=BFBF_FFFC. Cycle 1: ce=1, inst_sram_addr=BFC0_0000, en=1. Cycle 2: addr=BFC0_0004.
- Taken branch: pc_reg=BFC0_0010, br_bus={1,BFC0_0100}, no stall → next pc BFC0_0100, then BFC0_0104.
- Branch under stall: pc_reg=BFC0_0020, stall[0]=1 for 3 cycles, br_e pulse {1,BFC0_0200} in the first stall cycle only → pc holds BFC0_0020 throughout the stall. First unstalled edge loads BFC0_0200; pend_valid=0 afterwards.
- Flush priority: flush=1, flush_pc=BFC0_0380, br_e=1 with br_addr=BFC0_0500, stall[0]=1, same cycle → pc=BFC0_0380 next cycle; no later jump to BFC0_0500.
- Misaligned target: br_addr=BFC0_0402 → inst_sram_en=0, if_to_id_bus ce=0, fetch_adel=1, fetch_badvaddr=BFC0_0402. Then flush to BFC0_0380 → adel=0.
- Wrap: force pc_reg=FFFF_FFFC via branch → next pc=0000_0000, ce=1, adel=0.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Bundle of every signal between the IF stage and its neighbours: stall/redirect from
// the pipeline, the instruction SRAM request and the IF->ID bus.
interface if_fetch_stage_if #(
    parameter int IF_TO_ID_WD = 33,
    parameter int BR_WD       = 33,
    parameter int STALL_WD    = 6
);
    logic [STALL_WD-1:0]    stall;
    logic                   flush;
    logic [31:0]            flush_pc;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic                   fetch_adel;
    logic [31:0]            fetch_badvaddr;

    // The fetch stage itself.
    modport master (
        input  stall, flush, flush_pc, br_bus,
        output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, fetch_adel, fetch_badvaddr
    );

    // The surrounding pipeline / memory side.
    modport slave (
        output stall, flush, flush_pc, br_bus,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, fetch_adel, fetch_badvaddr
    );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues SRAM reads and remembers a branch
// target that arrived while the PC was frozen.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_stage_if.master  bus
);
    localparam logic STOP = 1'b1;

    logic [31:0] pc_r;
    logic        ce_r;
    logic        pend_valid_r;
    logic [31:0] pend_addr_r;

    logic        br_e_s;
    logic [31:0] br_addr_s;
    logic        stop_s;
    logic [31:0] next_pc_s;
    logic        misaligned_s;
    logic        unused_stall_s;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    assign br_e_s         = bus.br_bus[32];
    assign br_addr_s      = bus.br_bus[31:0];
    assign stop_s         = bus.stall[0];
    assign unused_stall_s = ^bus.stall[5:1];

    // Next-PC selection: flush, then live branch, then remembered branch, then sequential.
    always_comb begin
        next_pc_s = pc_r + 32'd4;
        if (bus.flush) begin
            next_pc_s = bus.flush_pc;
        end else if (br_e_s) begin
            next_pc_s = br_addr_s;
        end else if (pend_valid_r) begin
            next_pc_s = pend_addr_r;
        end else begin
            next_pc_s = pc_r + 32'd4;
        end
    end

    // PC, fetch-enable and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC - 32'd4;
            ce_r         <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_addr_r  <= 32'd0;
        end else begin
            ce_r <= 1'b1;
            if (bus.flush) begin
                pc_r         <= bus.flush_pc;
                pend_valid_r <= 1'b0;
            end else if (stop_s != STOP) begin
                pc_r         <= next_pc_s;
                pend_valid_r <= 1'b0;
            end else if (br_e_s) begin
                // A newer redirect replaces any older remembered one.
                pend_valid_r <= 1'b1;
                pend_addr_r  <= br_addr_s;
            end else begin
                pend_valid_r <= pend_valid_r;
                pend_addr_r  <= pend_addr_r;
            end
        end
    end

    // Request and status outputs; a misaligned PC becomes a bubble plus an address error.
    always_comb begin
        misaligned_s        = is_misaligned(pc_r);
        bus.inst_sram_addr  = pc_r;
        bus.inst_sram_en    = ce_r & ~misaligned_s;
        bus.inst_sram_wen   = 4'b0000;
        bus.inst_sram_wdata = 32'd0;
        bus.if_to_id_bus    = {ce_r & ~misaligned_s, pc_r};
        bus.fetch_adel      = ce_r & misaligned_s;
        if (ce_r & misaligned_s) begin
            bus.fetch_badvaddr = pc_r;
        end else begin
            bus.fetch_badvaddr = 32'd0;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic
// against a behavioural fetch-address model.
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic clk;
    logic rst;
    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: address being fetched, fetch started, remembered redirect.
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pv;
    logic [31:0] m_pa;

    // One clock: apply the architectural update rules to the model, then advance.
    task automatic step();
        logic [31:0] n_pc;
        logic        n_ce, n_pv;
        logic [31:0] n_pa;
        n_pc = m_pc; n_ce = m_ce; n_pv = m_pv; n_pa = m_pa;
        if (rst) begin
            n_pc = RESET_PC - 32'd4; n_ce = 1'b0; n_pv = 1'b0; n_pa = 32'd0;
        end else begin
            n_ce = 1'b1;
            if (bus.flush) begin
                n_pc = bus.flush_pc; n_pv = 1'b0;
            end else if (!bus.stall[0]) begin
                if (bus.br_bus[32]) n_pc = bus.br_bus[31:0];
                else if (m_pv)      n_pc = m_pa;
                else                n_pc = m_pc + 32'd4;
                n_pv = 1'b0;
            end else if (bus.br_bus[32]) begin
                n_pv = 1'b1; n_pa = bus.br_bus[31:0];
            end
        end
        @(posedge clk);
        m_pc = n_pc; m_ce = n_ce; m_pv = n_pv; m_pa = n_pa;
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 6'd0; bus.flush = 1'b0; bus.flush_pc = 32'd0; bus.br_bus = 33'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        vectors++;
        if (bus.if_to_id_bus !== {1'b0, 32'hBFBF_FFFC}) begin
            miscompares++; $display("FAIL reset_bus got %h want %h", bus.if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
        end
        vectors++;
        if ({bus.inst_sram_en, bus.fetch_adel, bus.fetch_badvaddr} !== 34'd0) begin
            miscompares++; $display("FAIL reset_outs got en=%b adel=%b bad=%h want 0", bus.inst_sram_en, bus.fetch_adel, bus.fetch_badvaddr);
        end
        step();
        vectors++;
        if ({bus.inst_sram_en, bus.if_to_id_bus[32], bus.inst_sram_addr} !== {2'b11, 32'hBFC0_0000}) begin
            miscompares++; $display("FAIL start_fetch got en=%b ce=%b addr=%h want 1 1 bfc00000", bus.inst_sram_en, bus.if_to_id_bus[32], bus.inst_sram_addr);
        end
        step();
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0004) begin
            miscompares++; $display("FAIL second_fetch got %h want bfc00004", bus.inst_sram_addr);
        end
    endtask

    task automatic test_branch();
        bus.flush = 1'b1; bus.flush_pc = 32'hBFC0_0010; step(); bus.flush = 1'b0;
        bus.br_bus = {1'b1, 32'hBFC0_0100}; step(); bus.br_bus = 33'd0;
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0100) begin
            miscompares++; $display("FAIL branch_taken got %h want bfc00100", bus.inst_sram_addr);
        end
        step();
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0104) begin
            miscompares++; $display("FAIL branch_seq got %h want bfc00104", bus.inst_sram_addr);
        end
    endtask

    task automatic test_branch_stall();
        bus.flush = 1'b1; bus.flush_pc = 32'hBFC0_0020; step(); bus.flush = 1'b0;
        bus.stall = 6'b000001;
        bus.br_bus = {1'b1, 32'hBFC0_0200}; step(); bus.br_bus = 33'd0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bus.inst_sram_addr !== 32'hBFC0_0020) begin
                miscompares++; $display("FAIL stall_hold[%0d] got %h want bfc00020", i, bus.inst_sram_addr);
            end
            step();
        end
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0020) begin
            miscompares++; $display("FAIL stall_hold_end got %h want bfc00020", bus.inst_sram_addr);
        end
        bus.stall = 6'd0; step();
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0200) begin
            miscompares++; $display("FAIL pending_load got %h want bfc00200", bus.inst_sram_addr);
        end
        step();
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0204) begin
            miscompares++; $display("FAIL pending_clear got %h want bfc00204", bus.inst_sram_addr);
        end
    endtask

    task automatic test_flush_priority();
        bus.flush = 1'b1; bus.flush_pc = 32'hBFC0_0380;
        bus.br_bus = {1'b1, 32'hBFC0_0500}; bus.stall = 6'b000001;
        step();
        bus.flush = 1'b0; bus.br_bus = 33'd0;
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0380) begin
            miscompares++; $display("FAIL flush_wins got %h want bfc00380", bus.inst_sram_addr);
        end
        step();
        bus.stall = 6'd0; step();
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0384) begin
            miscompares++; $display("FAIL flush_drops_branch got %h want bfc00384", bus.inst_sram_addr);
        end
    endtask

    task automatic test_misaligned();
        bus.br_bus = {1'b1, 32'hBFC0_0402}; step(); bus.br_bus = 33'd0;
        vectors++;
        if ({bus.inst_sram_en, bus.if_to_id_bus[32], bus.fetch_adel} !== 3'b001) begin
            miscompares++; $display("FAIL misalign_flags got en=%b ce=%b adel=%b want 0 0 1", bus.inst_sram_en, bus.if_to_id_bus[32], bus.fetch_adel);
        end
        vectors++;
        if (bus.fetch_badvaddr !== 32'hBFC0_0402) begin
            miscompares++; $display("FAIL misalign_badvaddr got %h want bfc00402", bus.fetch_badvaddr);
        end
        bus.flush = 1'b1; bus.flush_pc = 32'hBFC0_0380; step(); bus.flush = 1'b0;
        vectors++;
        if ({bus.fetch_adel, bus.inst_sram_en, bus.fetch_badvaddr} !== {2'b01, 32'd0}) begin
            miscompares++; $display("FAIL misalign_recover got adel=%b en=%b bad=%h want 0 1 0", bus.fetch_adel, bus.inst_sram_en, bus.fetch_badvaddr);
        end
    endtask

    task automatic test_wrap();
        bus.br_bus = {1'b1, 32'hFFFF_FFFC}; step(); bus.br_bus = 33'd0;
        step();
        vectors++;
        if ({bus.if_to_id_bus, bus.fetch_adel} !== {1'b1, 32'h0000_0000, 1'b0}) begin
            miscompares++; $display("FAIL wrap got bus=%h adel=%b want 100000000 0", bus.if_to_id_bus, bus.fetch_adel);
        end
    endtask

    task automatic test_reset_pending();
        bus.stall = 6'b000001; bus.br_bus = {1'b1, 32'hBFC0_0700}; step(); bus.br_bus = 33'd0;
        rst = 1'b1; step(); rst = 1'b0;
        vectors++;
        if (bus.if_to_id_bus !== {1'b0, 32'hBFBF_FFFC}) begin
            miscompares++; $display("FAIL reset_mid_pend got %h want %h", bus.if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
        end
        bus.stall = 6'd0; step();
        vectors++;
        if (bus.inst_sram_addr !== RESET_PC) begin
            miscompares++; $display("FAIL reset_drops_pend got %h want %h", bus.inst_sram_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic        exp_mis;
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.stall = {5'($urandom()), ($urandom_range(0, 2) == 0)};
            bus.flush = ($urandom_range(0, 15) == 0);
            a = $urandom();
            bus.flush_pc = {a[31:2], 2'b00};
            a = $urandom();
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            bus.br_bus = {($urandom_range(0, 3) == 0), a};
            step();
            exp_mis = (m_pc % 32'd4) != 32'd0;
            vectors++;
            if (bus.if_to_id_bus !== {m_ce && !exp_mis, m_pc} || bus.inst_sram_addr !== m_pc) begin
                miscompares++; $display("FAIL rand_pc[%0d] got bus=%h addr=%h want ce=%b pc=%h", i, bus.if_to_id_bus, bus.inst_sram_addr, m_ce && !exp_mis, m_pc);
            end
            vectors++;
            if (bus.inst_sram_en !== (m_ce && !exp_mis) || bus.fetch_adel !== (m_ce && exp_mis) ||
                bus.fetch_badvaddr !== ((m_ce && exp_mis) ? m_pc : 32'd0)) begin
                miscompares++; $display("FAIL rand_status[%0d] got en=%b adel=%b bad=%h model pc=%h ce=%b", i, bus.inst_sram_en, bus.fetch_adel, bus.fetch_badvaddr, m_pc, m_ce);
            end
            vectors++;
            if (bus.inst_sram_wen !== 4'b0000 || bus.inst_sram_wdata !== 32'd0) begin
                miscompares++; $display("FAIL rand_write_tie[%0d] got wen=%h wdata=%h want 0 0", i, bus.inst_sram_wen, bus.inst_sram_wdata);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        m_pc = 32'd0; m_ce = 1'b0; m_pv = 1'b0; m_pa = 32'd0;
        test_reset();
        test_branch();
        test_branch_stall();
        test_flush_priority();
        test_misaligned();
        test_wrap();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
